// File: rtl/baud_tick_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : baud_tick_gen_if                                              |
// | Purpose  : Configuration and tick bundle between the register/config     |
// |            side (master) and the baud engine (slave).                    |
// | Signals  : baud_rate/baud_load/enable   master -> slave                  |
// |            busy/cfg_valid/baud_err/cfg_divider/os_tick/bit_tick/phase    |
// |                                         slave -> master                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface baud_tick_gen_if #(
    parameter int BAUD_W = 20,
    parameter int OS_W   = 4
);
    logic [BAUD_W-1:0] baud_rate;
    logic              baud_load;
    logic              enable;
    logic              busy;
    logic              cfg_valid;
    logic              baud_err;
    logic [31:0]       cfg_divider;
    logic              os_tick;
    logic              bit_tick;
    logic [OS_W-1:0]   phase;

    modport master (
        output baud_rate, baud_load, enable,
        input  busy, cfg_valid, baud_err, cfg_divider, os_tick, bit_tick, phase
    );

    modport slave (
        input  baud_rate, baud_load, enable,
        output busy, cfg_valid, baud_err, cfg_divider, os_tick, bit_tick, phase
    );
endinterface
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : baud_tick_gen                                                 |
// | Purpose  : Runtime-programmable baud engine. A 32-cycle restoring        |
// |            divider turns the requested baud into the legacy integer      |
// |            divider, and a phase accumulator (NCO) emits exact-average    |
// |            oversample and bit ticks.                                     |
// | Ports    : clk     - system clock                                        |
// |            resetn  - synchronous active-low reset                        |
// |            bus     - baud_tick_gen_if.slave (request in, status/ticks    |
// |                      out)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module baud_tick_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_W     = 20,
    parameter int MIN_BAUD   = 300
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    baud_tick_gen_if.slave   bus
);

    localparam int                  C_OS_LOG  = $clog2(OVERSAMPLE);
    localparam int                  C_ACC_W   = $clog2(CLK_FREQ) + 2;
    localparam logic [31:0]         C_CLK     = 32'(CLK_FREQ);
    localparam logic [31:0]         C_HALF    = 32'(CLK_FREQ / 2);
    localparam logic [31:0]         C_MIN     = 32'(MIN_BAUD);
    localparam logic [C_ACC_W-1:0]  C_CLK_ACC = C_ACC_W'(CLK_FREQ);
    localparam logic [C_OS_LOG-1:0] C_PH_LAST = C_OS_LOG'(OVERSAMPLE - 1);

    // Status / output registers
    logic                busy_q;
    logic                cfg_valid_q;
    logic                baud_err_q;
    logic [31:0]         cfg_div_q;
    logic                os_tick_q;
    logic                bit_tick_q;
    logic [C_OS_LOG-1:0] phase_q;

    // NCO state
    logic [C_ACC_W-1:0]  acc_q;
    logic [C_ACC_W-1:0]  step_q;

    // Divider state
    logic [31:0]         div_q;   // divisor d
    logic [31:0]         rem_q;   // partial remainder, always < d
    logic [31:0]         quo_q;   // dividend bits shift out, quotient bits shift in
    logic [4:0]          iter_q;

    // Request decode
    logic [31:0]         baud_ext;
    logic [31:0]         d_req;
    logic                req_bad;

    // Divider next state
    logic [32:0]         rem_sh;
    logic                rem_ge;
    logic [31:0]         rem_d;
    logic [31:0]         quo_d;

    // NCO next state
    logic [C_ACC_W-1:0]  acc_sum;
    logic                acc_wrap;
    logic [C_ACC_W-1:0]  acc_d;
    logic [C_OS_LOG-1:0] phase_d;

    assign baud_ext = 32'(bus.baud_rate);
    // OVERSAMPLE is a power of two; BAUD_W + log2(OVERSAMPLE) <= 32 keeps this exact.
    assign d_req    = baud_ext << C_OS_LOG;
    assign req_bad  = (baud_ext < C_MIN) || (d_req > C_HALF);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // The 32-bit subtraction is exact because the result is always below d.
    assign rem_sh = {rem_q, quo_q[31]};
    assign rem_ge = (rem_sh >= {1'b0, div_q});
    assign rem_d  = rem_sh[31:0] - (rem_ge ? div_q : 32'd0);
    assign quo_d  = {quo_q[30:0], rem_ge};

    // acc < CLK_FREQ and step <= CLK_FREQ/2, so the sum never overflows C_ACC_W.
    assign acc_sum  = acc_q + step_q;
    assign acc_wrap = (acc_sum >= C_CLK_ACC);
    assign acc_d    = acc_wrap ? (acc_sum - C_CLK_ACC) : acc_sum;
    assign phase_d  = phase_q + C_OS_LOG'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            baud_err_q  <= 1'b0;
            cfg_div_q   <= 32'hFFFF_FFFF;
            os_tick_q   <= 1'b0;
            bit_tick_q  <= 1'b0;
            phase_q     <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            iter_q      <= '0;
        end else begin
            // Ticks are single-cycle pulses unless re-asserted below.
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;

            if (busy_q) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                iter_q <= iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    // Final quotient bit lands here; publish everything together.
                    busy_q      <= 1'b0;
                    cfg_valid_q <= 1'b1;
                    cfg_div_q   <= quo_d - 32'd1;
                    step_q      <= C_ACC_W'(div_q);
                    acc_q       <= '0;
                    phase_q     <= '0;
                end
            end else if (bus.baud_load) begin
                if (req_bad) begin
                    baud_err_q  <= 1'b1;
                    cfg_valid_q <= 1'b0;
                    cfg_div_q   <= 32'hFFFF_FFFF;
                    step_q      <= '0;
                    acc_q       <= '0;
                    phase_q     <= '0;
                end else begin
                    busy_q      <= 1'b1;
                    cfg_valid_q <= 1'b0;
                    baud_err_q  <= 1'b0;
                    div_q       <= d_req;
                    rem_q       <= '0;
                    quo_q       <= C_CLK;
                    iter_q      <= '0;
                end
            end else if (bus.enable && cfg_valid_q) begin
                acc_q <= acc_d;
                if (acc_wrap) begin
                    os_tick_q  <= 1'b1;
                    // Bit tick coincides with the tick that brings phase to its last value.
                    bit_tick_q <= (phase_d == C_PH_LAST);
                    phase_q    <= phase_d;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.cfg_valid   = cfg_valid_q;
    assign bus.baud_err    = baud_err_q;
    assign bus.cfg_divider = cfg_div_q;
    assign bus.os_tick     = os_tick_q;
    assign bus.bit_tick    = bit_tick_q;
    assign bus.phase       = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_baud_tick_gen                                              |
// | Purpose  : Self-checking bench for baud_tick_gen. Loads push expected    |
// |            results into a queue; a monitor pops and compares whenever a  |
// |            request completes. Tick counts are checked over exact windows.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_baud_tick_gen;

    typedef struct {
        int          baud;
        bit          err;
        bit          valid;
        logic [31:0] div;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_fail;
    exp_t sb[$];

    baud_tick_gen_if #(.BAUD_W(21), .OS_W(4)) bus ();

    baud_tick_gen #(
        .CLK_FREQ   (50_000_000),
        .OVERSAMPLE (16),
        .BAUD_W     (21),
        .MIN_BAUD   (300)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {23'd0, bus.busy, bus.cfg_valid, bus.baud_err, bus.cfg_divider,
                     bus.os_tick, bus.bit_tick, bus.phase},
              {23'd0, 3'b000, 32'hFFFF_FFFF, 2'b00, 4'd0});
    endtask

    // Issue a single-cycle load; optionally register the expected outcome.
    task automatic load(input int baud, input bit push, input bit err, input logic [31:0] div);
        exp_t e;
        @(posedge clk); #1;
        bus.baud_rate = 21'(baud);
        bus.baud_load = 1'b1;
        if (push) begin
            e.baud  = baud;
            e.err   = err;
            e.valid = !err;
            e.div   = div;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.baud_load = 1'b0;
    endtask

    // Called right after load(): returns at the negedge where busy is low again.
    task automatic wait_done(output int busy_cycles);
        bit done;
        busy_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            else          done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL busy_timeout: busy still high after 40 cycles, expected low");
        end
    endtask

    // Scoreboard monitor: a result is presented when busy falls, or when an
    // accepted load leaves busy low (out-of-range path).
    initial begin : monitor
        bit   prev_rstn;
        bit   prev_busy;
        bit   prev_load;
        exp_t e;
        prev_rstn = 1'b0;
        prev_busy = 1'b0;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_rstn && !bus.busy && (prev_busy || (prev_load && !prev_busy))) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got err=%b valid=%b div=%0d, expected no result",
                             bus.baud_err, bus.cfg_valid, bus.cfg_divider);
                end else begin
                    e = sb.pop_front();
                    if (bus.baud_err !== e.err || bus.cfg_valid !== e.valid ||
                        bus.cfg_divider !== e.div || bus.phase !== 4'd0) begin
                        n_fail++;
                        $display("FAIL result_baud_%0d: got err=%b valid=%b div=%0d phase=%0d, expected err=%b valid=%b div=%0d phase=0",
                                 e.baud, bus.baud_err, bus.cfg_valid, bus.cfg_divider, bus.phase,
                                 e.err, e.valid, e.div);
                    end
                end
            end
            prev_rstn = resetn;
            prev_busy = bus.busy;
            prev_load = bus.baud_load;
        end
    end

    initial begin : stimulus
        int bc;
        int first;
        int ticks;
        int bits;
        int adj;
        int bad_bit;
        int gap_ticks;
        bit prev_tick;
        bit flag;
        logic [3:0] ph_hold;

        n_vec  = 0;
        n_fail = 0;
        resetn        = 1'b0;
        bus.baud_rate = '0;
        bus.baud_load = 1'b0;
        bus.enable    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_state");
        @(posedge clk); #1;
        resetn     = 1'b1;
        bus.enable = 1'b1;

        // 115200 baud: 32 busy cycles, divider 26
        load(115200, 1, 0, 32'd26);
        wait_done(bc);
        check("busy_cycles_115200", bc, 32);

        // Tick cadence over 31250 cycles (= 1152 ticks exactly, acc returns to 0)
        first = 0; ticks = 0; bits = 0; adj = 0; bad_bit = 0; prev_tick = 1'b0;
        for (int n = 1; n <= 31250; n++) begin
            @(negedge clk);
            if (bus.os_tick) begin
                ticks++;
                if (first == 0) first = n;
                if (prev_tick) adj++;
            end
            if (bus.bit_tick) begin
                bits++;
                if (!bus.os_tick || bus.phase != 4'd15) bad_bit++;
            end
            prev_tick = bus.os_tick;
        end
        check("first_os_tick_cycle", first, 28);
        check("os_tick_count", ticks, 1152);
        check("bit_tick_count", bits, 72);
        check("adjacent_os_ticks", adj, 0);
        check("bit_tick_alignment", bad_bit, 0);

        // Sequential loads, including the d == CLK_FREQ/2 and MIN_BAUD boundaries
        load(9600, 1, 0, 32'd324);
        wait_done(bc);
        check("busy_cycles_9600", bc, 32);
        load(921600, 1, 0, 32'd2);
        wait_done(bc);
        load(300, 1, 0, 32'd10415);
        wait_done(bc);
        load(1562500, 1, 0, 32'd1);
        wait_done(bc);

        // Out-of-range requests
        load(1843200, 1, 1, 32'hFFFF_FFFF);
        wait_done(bc);
        check("busy_cycles_err", bc, 0);
        load(299, 1, 1, 32'hFFFF_FFFF);
        wait_done(bc);
        load(1562501, 1, 1, 32'hFFFF_FFFF);
        wait_done(bc);
        ticks = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.os_tick || bus.bit_tick) ticks++;
        end
        check("ticks_while_err", ticks, 0);
        load(9600, 1, 0, 32'd324);
        wait_done(bc);

        // Load while busy is ignored; result is the first request's
        load(921600, 1, 0, 32'd2);
        repeat (9) @(posedge clk);
        load(300, 0, 0, 32'd0);
        wait_done(bc);

        // Reset during a computation aborts it
        load(115200, 0, 0, 32'd0);
        repeat (19) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("reset_mid_division");
        @(posedge clk); #1;
        resetn = 1'b1;
        flag = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.cfg_valid || bus.busy) flag = 1'b1;
        end
        check("no_result_after_reset", flag, 0);

        // Enable gap of 100 cycles mid-run: 31250 enabled cycles -> 1152 ticks
        load(115200, 1, 0, 32'd26);
        wait_done(bc);
        ticks = 0; bits = 0; gap_ticks = 0; ph_hold = 4'd0; flag = 1'b0;
        for (int n = 1; n <= 31350; n++) begin
            @(negedge clk);
            if (bus.os_tick) ticks++;
            if (bus.bit_tick) bits++;
            if (n > 15000 && n <= 15100 && (bus.os_tick || bus.bit_tick)) gap_ticks++;
            if (n == 15000) ph_hold = bus.phase;
            if (n == 15100 && bus.phase !== ph_hold) flag = 1'b1;
            bus.enable = !(n >= 15000 && n < 15100);
        end
        check("ticks_during_gap", gap_ticks, 0);
        check("phase_held_in_gap", flag, 0);
        check("os_tick_count_gap", ticks, 1152);
        check("bit_tick_count_gap", bits, 72);

        repeat (5) @(negedge clk);
        check("pending_expectations", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
